frame_player: RTL and testbench

//  Consumes the byte stream recovered by the RGMII frame receiver: payload bytes (addr/data),
//  the per-frame divider byte and the last-payload index ("cycle"). Stores each frame in a

---
 rtl/frame_pkg.sv | 13 +
 rtl/frame_player_pp_ram.sv | 37 +++
 rtl/frame_player.sv | 125 ++++++++++++
 tb/tb_frame_player.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types and default sizes for the frame player and its buffer RAM.
package frame_pkg;

  localparam int AW_DEFAULT    = 13;
  localparam int DW_DEFAULT    = 8;
  localparam int DEPTH_DEFAULT = 4096;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/frame_player_pp_ram.sv
// Ping-pong frame buffer: two banks of DEPTH bytes in one array, the bank
// select is the address MSB. One write port and one registered read port;
// the read register holds its value when no read is requested.
module pp_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 4096,
  parameter int RAW   = $clog2(2 * DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           we,
  input  logic [RAW-1:0] waddr,
  input  logic [DW-1:0]  wdata,
  input  logic           re,
  input  logic [RAW-1:0] raddr,
  output logic [DW-1:0]  rdata
);

  logic [DW-1:0] mem [2*DEPTH];

  // store incoming payload bytes; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // registered read, cleared on reset so the sample output starts at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_player.sv
// Frame player: buffers each received frame in the idle bank of a ping-pong
// RAM, swaps banks when the frame completes and loops the new frame out one
// sample every (div+1) enabled clocks.
module frame_player
  import frame_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [7:0]    cfg_div,
  input  logic [AW-1:0] cfg_cycle,
  input  logic          frame_done,
  input  logic          en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic [AW-1:0] rd_addr,
  output logic          bank,
  output logic          playing,
  output logic          overrun
);

  localparam int IW  = $clog2(DEPTH);
  localparam int RAW = IW + 1;
  localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_t        state;
  state_t        state_next;
  logic [7:0]    div_r;
  logic [7:0]    presc;
  logic [IW-1:0] len_r;
  logic [IW-1:0] ptr;
  logic          wr_oob;
  logic          tick;

  // writes beyond one bank are dropped and flagged
  assign wr_oob = ({1'b0, wr_addr} >= DEPTH_EXT);

  // a sample is due when the prescaler has counted up to the divider;
  // the frame_done cycle never produces one because it restarts everything
  assign tick = (state == PLAY) && en && !frame_done && (presc == div_r);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // leave IDLE on the first completed frame; further frames simply re-arm PLAY
  always_comb begin
    state_next = state;
    if (frame_done) begin
      state_next = PLAY;
    end
  end

  // state-derived outputs
  always_comb begin
    playing = (state == PLAY);
  end

  // frame configuration, bank swap, prescaler, read pointer and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank       <= 1'b0;
      div_r      <= '0;
      len_r      <= '0;
      ptr        <= '0;
      presc      <= '0;
      rd_addr    <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= tick;
      if (wr_en && wr_oob) begin
        overrun <= 1'b1;
      end
      if (frame_done) begin
        div_r <= cfg_div;
        if (cfg_cycle > LAST) begin
          len_r   <= IW'(DEPTH - 1);
          overrun <= 1'b1;
        end else begin
          len_r <= cfg_cycle[IW-1:0];
        end
        bank  <= ~bank;
        ptr   <= '0;
        presc <= '0;
      end else if ((state == PLAY) && en) begin
        if (tick) begin
          presc   <= '0;
          rd_addr <= AW'(ptr);
          ptr     <= (ptr == len_r) ? '0 : ptr + IW'(1);
        end else begin
          presc <= presc + 8'd1;
        end
      end
    end
  end

  pp_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .RAW   (RAW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en && !wr_oob),
    .waddr ({~bank, wr_addr[IW-1:0]}),
    .wdata (wr_data),
    .re    (tick),
    .raddr ({bank, ptr}),
    .rdata (dout)
  );

endmodule

// File: tb/tb_frame_player.sv
// Self-checking bench for frame_player: directed scenarios with literal
// expectations plus randomized frames, all compared against a sample-index
// reference model every cycle.
module tb_frame_player;

  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [7:0]    cfg_div = '0;
  logic [AW-1:0] cfg_cycle = '0;
  logic          frame_done = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [AW-1:0] rd_addr;
  logic          bank;
  logic          playing;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  frame_player #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cfg_div    (cfg_div),
    .cfg_cycle  (cfg_cycle),
    .frame_done (frame_done),
    .en         (en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .rd_addr    (rd_addr),
    .bank       (bank),
    .playing    (playing),
    .overrun    (overrun)
  );

  // free-running system clock
  always #5 clk = ~clk;

  // reference model: samples are numbered by enabled cycles since the last
  // frame_done; sample k appears once k*(div+1) enabled cycles have passed
  logic [7:0] mem [0:2*DEPTH-1];
  bit         m_play;
  bit         m_bank;
  int         m_div;
  int         m_len;
  int         m_cnt;
  int         m_dout;
  int         m_rdaddr;
  bit         m_valid;
  bit         m_ovr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_play = 0; m_bank = 0; m_div = 0; m_len = 0; m_cnt = 0;
      m_dout = 0; m_rdaddr = 0; m_valid = 0; m_ovr = 0;
    end else begin
      m_valid = 0;
      if (wr_en) begin
        if (int'(wr_addr) >= DEPTH) m_ovr = 1;
        else mem[(m_bank ? 0 : DEPTH) + int'(wr_addr)] = wr_data;
      end
      if (frame_done) begin
        m_div = int'(cfg_div);
        if (int'(cfg_cycle) > DEPTH - 1) begin
          m_len = DEPTH - 1;
          m_ovr = 1;
        end else begin
          m_len = int'(cfg_cycle);
        end
        m_bank = !m_bank;
        m_cnt  = 0;
        m_play = 1;
      end else if (m_play && en) begin
        m_cnt++;
        if (m_cnt % (m_div + 1) == 0) begin
          int idx;
          idx      = m_cnt / (m_div + 1) - 1;
          m_rdaddr = idx % (m_len + 1);
          m_dout   = int'(mem[(m_bank ? DEPTH : 0) + m_rdaddr]);
          m_valid  = 1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare every DUT output against the model once per cycle
  always @(negedge clk) begin
    checkOutput("cmp_valid",   int'(dout_valid), int'(m_valid));
    checkOutput("cmp_dout",    int'(dout),       m_dout);
    checkOutput("cmp_rd_addr", int'(rd_addr),    m_rdaddr);
    checkOutput("cmp_bank",    int'(bank),       int'(m_bank));
    checkOutput("cmp_playing", int'(playing),    int'(m_play));
    checkOutput("cmp_overrun", int'(overrun),    int'(m_ovr));
  end

  // drive one cycle of inputs, then return the strobes to idle
  task automatic applyStimulus(input logic we, input int addr, input int data,
                               input logic fd, input int div, input int cyc,
                               input logic en_v);
    wr_en      = we;
    wr_addr    = AW'(addr);
    wr_data    = DW'(data);
    frame_done = fd;
    cfg_div    = 8'(div);
    cfg_cycle  = AW'(cyc);
    en         = en_v;
    @(posedge clk);
    #1;
    wr_en      = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic expectSample(input string name, input int val, input int addr);
    @(negedge clk);
    checkOutput({name, "_valid"}, int'(dout_valid), 1);
    checkOutput({name, "_dout"},  int'(dout),       val);
    checkOutput({name, "_addr"},  int'(rd_addr),    addr);
  endtask

  task automatic expectIdle(input string name, input int n);
    repeat (n) begin
      @(negedge clk);
      checkOutput(name, int'(dout_valid), 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dout",    int'(dout),       0);
    checkOutput("rst_valid",   int'(dout_valid), 0);
    checkOutput("rst_rd_addr", int'(rd_addr),    0);
    checkOutput("rst_bank",    int'(bank),       0);
    checkOutput("rst_playing", int'(playing),    0);
    checkOutput("rst_overrun", int'(overrun),    0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // frame 1, div 0: one sample per cycle starting two cycles after frame_done
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, i, 8'h10 + i, 1'b0, 0, 0, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b1, 0, 3, 1'b1);
    expectIdle("t1_gap", 1);
    for (int k = 0; k < 5; k++) expectSample("t1", 8'h10 + (k % 4), k % 4);
    checkOutput("t1_bank", int'(bank), 1);
    checkOutput("t1_playing", int'(playing), 1);

    // same bytes into the other bank, div 2: first sample at F+4, then every 3rd
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, i, 8'h10 + i, 1'b0, 0, 0, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b1, 2, 3, 1'b1);
    expectIdle("t2_gap", 3);
    expectSample("t2_s0", 8'h10, 0);
    expectIdle("t2_gap2", 2);
    expectSample("t2_s1", 8'h11, 1);
    checkOutput("t2_bank", int'(bank), 0);

    // mid-play two-byte frame
    applyStimulus(1'b1, 0, 8'hA0, 1'b0, 0, 0, 1'b1);
    applyStimulus(1'b1, 1, 8'hA1, 1'b0, 0, 0, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b1, 0, 1, 1'b1);
    expectIdle("t3_gap", 1);
    expectSample("t3_s0", 8'hA0, 0);
    expectSample("t3_s1", 8'hA1, 1);
    expectSample("t3_s2", 8'hA0, 0);
    checkOutput("t3_bank", int'(bank), 1);

    // swap back without writing: the previous frame is still in bank 0
    applyStimulus(1'b0, 0, 0, 1'b1, 0, 3, 1'b1);
    expectIdle("t3b_gap", 1);
    for (int k = 0; k < 4; k++) expectSample("t3b", 8'h10 + k, k);
    checkOutput("t3b_bank", int'(bank), 0);

    // enable low for five cycles freezes everything; playback resumes in order
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("t4_valid", int'(dout_valid), 0);
      checkOutput("t4_dout",  int'(dout),       8'h13);
      checkOutput("t4_addr",  int'(rd_addr),    3);
    end
    en = 1'b1;
    expectSample("t4_resume", 8'h10, 0);

    // out-of-range write and oversized frame length both raise overrun
    applyStimulus(1'b1, DEPTH, 8'hEE, 1'b0, 0, 0, 1'b1);
    checkOutput("t5_ovr_write", int'(overrun), 1);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, i, (i ^ (i >> 4)) & 8'hFF, 1'b0, 0, 0, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b1, 0, 5000, 1'b1);
    @(negedge clk);
    repeat (DEPTH) @(negedge clk);
    checkOutput("t5_last_addr", int'(rd_addr), DEPTH - 1);
    @(negedge clk);
    checkOutput("t5_wrap_addr", int'(rd_addr), 0);
    checkOutput("t5_ovr_sticky", int'(overrun), 1);

    // asynchronous reset while playing
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_dout",    int'(dout),       0);
    checkOutput("t6_valid",   int'(dout_valid), 0);
    checkOutput("t6_rd_addr", int'(rd_addr),    0);
    checkOutput("t6_bank",    int'(bank),       0);
    checkOutput("t6_playing", int'(playing),    0);
    checkOutput("t6_overrun", int'(overrun),    0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    expectIdle("t6_silent", 8);
    applyStimulus(1'b1, 0, 8'h5A, 1'b1, 0, 0, 1'b1);
    expectIdle("t6_gap", 1);
    expectSample("t6_s0", 8'h5A, 0);
    expectSample("t6_s1", 8'h5A, 0);
    checkOutput("t6_bank2", int'(bank), 1);

    // randomized frames, dividers, enable patterns and stray writes
    for (int f = 0; f < 25; f++) begin
      int len;
      int div;
      len = $urandom_range(1, 12);
      div = $urandom_range(0, 3);
      for (int i = 0; i < len; i++) begin
        applyStimulus(1'b1, i, int'($urandom_range(0, 255)), 1'b0, 0, 0,
                      $urandom_range(0, 4) != 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        applyStimulus(1'b1, $urandom_range(DEPTH, 2 * DEPTH - 1), 8'h77, 1'b0, 0, 0, 1'b1);
      end
      applyStimulus(1'b0, 0, 0, 1'b1, div, $urandom_range(0, len - 1),
                    $urandom_range(0, 4) != 0);
      repeat ($urandom_range(10, 40)) begin
        applyStimulus(1'b0, 0, 0, 1'b0, 0, 0, $urandom_range(0, 4) != 0);
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
